// File: rtl/revo_phase_lock_controller.sv
// revo_phase_lock_controller: confirms a periodic revo pattern, commits the BUFGMUX phase,
// and flywheels synthetic revo markers through short dropouts of the remote revo.
module revo_phase_lock_controller #(
    parameter int unsigned REVO_PERIOD   = 1280,
    parameter int unsigned WINDOW        = 1,
    parameter int unsigned CONFIRM_COUNT = 3,
    parameter int unsigned MAX_MISSES    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] pulse_word,
    input  logic       relock,
    output logic [1:0] select2,
    output logic [3:0] select4,
    output logic       phase_locked,
    output logic       holdover,
    output logic       revo_out,
    output logic [7:0] error_count
);
    typedef enum logic [1:0] {S_ACQUIRE, S_VERIFY, S_LOCKED, S_HOLDOVER} state_t;

    localparam logic [16:0] LO      = 17'(REVO_PERIOD - WINDOW);
    localparam logic [16:0] HI      = 17'(REVO_PERIOD + WINDOW);
    localparam logic [16:0] MISS_AT = 17'(REVO_PERIOD + WINDOW + 1);
    localparam logic [15:0] PER     = 16'(REVO_PERIOD);
    localparam logic [15:0] HOLD_LD = 16'(WINDOW + 2);
    localparam logic [3:0]  CONF    = 4'(CONFIRM_COUNT);
    localparam logic [3:0]  MAXM    = 4'(MAX_MISSES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  cand_q, cand_d, conf_q, conf_d, miss_q, miss_d, sel4_q, sel4_d;
    logic [1:0]  sel2_q, sel2_d;
    logic        revo_q, revo_d, pl_q, hold_q, err_inc;
    logic [7:0]  err_q, err_d;
    logic [16:0] cnt17;
    logic        pulse, valid, match, on_time, miss_now;
    logic [1:0]  word_sel2;

    assign cnt17     = {1'b0, cnt_q};
    assign pulse     = |pulse_word;
    assign valid     = pulse_word inside {4'b1111, 4'b1110, 4'b1100, 4'b1000};
    assign match     = valid && (pulse_word == cand_q);
    assign on_time   = (cnt17 >= LO) && (cnt17 <= HI);
    // A saturated counter also counts as a miss so very long periods cannot stall in LOCKED.
    assign miss_now  = (cnt17 == MISS_AT) || (&cnt_q);
    assign word_sel2 = (pulse_word == 4'b1111) ? 2'b11 :
                       (pulse_word == 4'b1100) ? 2'b01 :
                       (pulse_word == 4'b1000) ? 2'b10 : 2'b00;
    assign err_d     = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        cand_d  = cand_q;
        conf_d  = conf_q;
        miss_d  = miss_q;
        sel2_d  = sel2_q;
        sel4_d  = sel4_q;
        revo_d  = 1'b0;
        err_inc = 1'b0;
        if (relock) begin
            state_d = S_ACQUIRE;
            conf_d  = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                S_ACQUIRE: if (valid) begin
                    cand_d  = pulse_word;
                    cnt_d   = 16'd1;
                    conf_d  = 4'd1;
                    state_d = (CONF == 4'd1) ? S_LOCKED : S_VERIFY;
                    sel2_d  = (CONF == 4'd1) ? word_sel2 : sel2_q;
                    sel4_d  = (CONF == 4'd1) ? pulse_word : sel4_q;
                end
                S_VERIFY: if (pulse) begin
                    if (on_time && match) begin
                        cnt_d  = 16'd1;
                        conf_d = conf_q + 4'd1;
                        if (conf_q + 4'd1 == CONF) begin
                            state_d = S_LOCKED;
                            sel2_d  = word_sel2;
                            sel4_d  = pulse_word;
                        end
                    end else begin
                        state_d = S_ACQUIRE;
                    end
                end else if (cnt17 > HI) begin
                    state_d = S_ACQUIRE;
                end
                S_LOCKED: if (miss_now) begin
                    // Reload as if the revo had arrived on its nominal slot two cycles ago.
                    state_d = S_HOLDOVER;
                    miss_d  = 4'd1;
                    revo_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                    err_inc = pulse;
                end else if (pulse && on_time) begin
                    cnt_d   = 16'd1;
                    revo_d  = 1'b1;
                    err_inc = !match;
                end else begin
                    err_inc = pulse;
                end
                S_HOLDOVER: if (pulse && on_time && match) begin
                    state_d = S_LOCKED;
                    miss_d  = '0;
                    cnt_d   = 16'd1;
                    revo_d  = 1'b1;
                end else begin
                    err_inc = pulse;
                    if (miss_q >= MAXM && miss_now) begin
                        state_d = S_ACQUIRE;
                        miss_d  = '0;
                    end else if (cnt_q == PER) begin
                        // Last permitted miss keeps counting so the final window can still close.
                        revo_d = 1'b1;
                        miss_d = (miss_q < MAXM) ? miss_q + 4'd1 : miss_q;
                        cnt_d  = (miss_q < MAXM) ? 16'd1 : cnt_d;
                    end
                end
                default: state_d = S_ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ACQUIRE;
            cnt_q   <= '0;
            cand_q  <= '0;
            conf_q  <= '0;
            miss_q  <= '0;
            sel2_q  <= '0;
            sel4_q  <= '0;
            revo_q  <= 1'b0;
            pl_q    <= 1'b0;
            hold_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            conf_q  <= conf_d;
            miss_q  <= miss_d;
            sel2_q  <= sel2_d;
            sel4_q  <= sel4_d;
            revo_q  <= revo_d;
            pl_q    <= (state_d == S_LOCKED) || (state_d == S_HOLDOVER);
            hold_q  <= (state_d == S_HOLDOVER);
            err_q   <= err_d;
        end
    end

    assign select2      = sel2_q;
    assign select4      = sel4_q;
    assign phase_locked = pl_q;
    assign holdover     = hold_q;
    assign revo_out     = revo_q;
    assign error_count  = err_q;
endmodule

// File: tb/tb_revo_phase_lock_controller.sv
// tb_revo_phase_lock_controller: directed scenarios with hand-computed expectations,
// using REVO_PERIOD=16, WINDOW=1, CONFIRM_COUNT=3, MAX_MISSES=2.
module tb_revo_phase_lock_controller;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] pulse_word = 4'b0000;
    logic       relock = 1'b0;
    logic [1:0] select2;
    logic [3:0] select4;
    logic       phase_locked, holdover, revo_out;
    logic [7:0] error_count;
    int         tests = 0;
    int         fails = 0;

    revo_phase_lock_controller #(
        .REVO_PERIOD(16), .WINDOW(1), .CONFIRM_COUNT(3), .MAX_MISSES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pulse_word(pulse_word), .relock(relock),
        .select2(select2), .select4(select4), .phase_locked(phase_locked),
        .holdover(holdover), .revo_out(revo_out), .error_count(error_count)
    );

    always #5 clock = ~clock;

    task automatic step(input logic [3:0] w);
        pulse_word = w;
        @(posedge clock);
        #1;
        pulse_word = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000);
    endtask

    task automatic lock_1100();
        step(4'b1100); idle(15); step(4'b1100); idle(15); step(4'b1100);
    endtask

    task automatic test_reset();
        #12;
        tests++; if (select2 !== 2'b00) begin fails++; $display("FAIL reset_sel2: got %b want 00", select2); end
        tests++; if (select4 !== 4'b0000) begin fails++; $display("FAIL reset_sel4: got %b want 0000", select4); end
        tests++; if ({phase_locked, holdover, revo_out} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {phase_locked, holdover, revo_out}); end
        tests++; if (error_count !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", error_count); end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_verify_abort();
        step(4'b1000); idle(15); step(4'b1111);
        tests++; if (phase_locked !== 1'b0) begin fails++; $display("FAIL abort_pl: got %b want 0", phase_locked); end
        idle(20);
        tests++; if (phase_locked !== 1'b0) begin fails++; $display("FAIL abort_pl_late: got %b want 0", phase_locked); end
        tests++; if (select2 !== 2'b00) begin fails++; $display("FAIL abort_sel2: got %b want 00", select2); end
        tests++; if (select4 !== 4'b0000) begin fails++; $display("FAIL abort_sel4: got %b want 0000", select4); end
    endtask

    task automatic test_lock();
        step(4'b1100); idle(15); step(4'b1100);
        tests++; if (phase_locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %b want 0", phase_locked); end
        idle(15); step(4'b1100);
        tests++; if (phase_locked !== 1'b1) begin fails++; $display("FAIL lock_pl: got %b want 1", phase_locked); end
        tests++; if (select2 !== 2'b01) begin fails++; $display("FAIL lock_sel2: got %b want 01", select2); end
        tests++; if (select4 !== 4'b1100) begin fails++; $display("FAIL lock_sel4: got %b want 1100", select4); end
    endtask

    task automatic test_jitter();
        idle(15); step(4'b1100);
        tests++; if (revo_out !== 1'b1) begin fails++; $display("FAIL jit_revo16: got %b want 1", revo_out); end
        idle(1);
        tests++; if (revo_out !== 1'b0) begin fails++; $display("FAIL jit_revo_drop: got %b want 0", revo_out); end
        idle(15); step(4'b1100);
        tests++; if (revo_out !== 1'b1) begin fails++; $display("FAIL jit_revo17: got %b want 1", revo_out); end
        tests++; if (error_count !== 8'd0) begin fails++; $display("FAIL jit_err17: got %0d want 0", error_count); end
        idle(11); step(4'b1100);
        tests++; if (revo_out !== 1'b0) begin fails++; $display("FAIL jit_revo12: got %b want 0", revo_out); end
        tests++; if (error_count !== 8'd1) begin fails++; $display("FAIL jit_err12: got %0d want 1", error_count); end
        idle(3); step(4'b1100);
        tests++; if (revo_out !== 1'b1) begin fails++; $display("FAIL jit_oldgrid: got %b want 1", revo_out); end
        idle(15); step(4'b1110);
        tests++; if (revo_out !== 1'b1) begin fails++; $display("FAIL jit_badpat_revo: got %b want 1", revo_out); end
        tests++; if (error_count !== 8'd2) begin fails++; $display("FAIL jit_badpat_err: got %0d want 2", error_count); end
    endtask

    task automatic test_holdover();
        idle(17);
        tests++; if ({holdover, revo_out} !== 2'b00) begin fails++; $display("FAIL hold_17: got %b want 00", {holdover, revo_out}); end
        idle(1);
        tests++; if ({phase_locked, holdover, revo_out} !== 3'b111) begin fails++; $display("FAIL hold_18: got %b want 111", {phase_locked, holdover, revo_out}); end
        idle(13);
        tests++; if (revo_out !== 1'b0) begin fails++; $display("FAIL hold_31: got %b want 0", revo_out); end
        idle(1);
        tests++; if (revo_out !== 1'b1) begin fails++; $display("FAIL hold_32: got %b want 1", revo_out); end
        idle(16);
        tests++; if ({holdover, revo_out} !== 2'b11) begin fails++; $display("FAIL hold_48: got %b want 11", {holdover, revo_out}); end
        idle(1);
        tests++; if ({holdover, revo_out} !== 2'b10) begin fails++; $display("FAIL hold_49: got %b want 10", {holdover, revo_out}); end
        idle(1);
        tests++; if ({phase_locked, holdover} !== 2'b00) begin fails++; $display("FAIL hold_drop: got %b want 00", {phase_locked, holdover}); end
        tests++; if (select2 !== 2'b01 || select4 !== 4'b1100) begin fails++; $display("FAIL hold_sel: got %b/%b want 01/1100", select2, select4); end
        tests++; if (error_count !== 8'd2) begin fails++; $display("FAIL hold_err: got %0d want 2", error_count); end
    endtask

    task automatic test_recovery();
        lock_1100();
        idle(18);
        tests++; if (holdover !== 1'b1) begin fails++; $display("FAIL rec_hold: got %b want 1", holdover); end
        idle(13); step(4'b1100);
        tests++; if ({phase_locked, holdover, revo_out} !== 3'b101) begin fails++; $display("FAIL rec_relock: got %b want 101", {phase_locked, holdover, revo_out}); end
        idle(1);
        tests++; if (revo_out !== 1'b0) begin fails++; $display("FAIL rec_single: got %b want 0", revo_out); end
        idle(14); step(4'b1100);
        tests++; if (revo_out !== 1'b1 || error_count !== 8'd2) begin fails++; $display("FAIL rec_next: got revo=%b err=%0d want revo=1 err=2", revo_out, error_count); end
    endtask

    task automatic test_relock();
        idle(15);
        relock = 1'b1;
        step(4'b1100);
        relock = 1'b0;
        tests++; if ({phase_locked, holdover, revo_out} !== 3'b000) begin fails++; $display("FAIL relock_flags: got %b want 000", {phase_locked, holdover, revo_out}); end
        tests++; if (select2 !== 2'b01) begin fails++; $display("FAIL relock_sel2: got %b want 01", select2); end
        tests++; if (error_count !== 8'd2) begin fails++; $display("FAIL relock_err: got %0d want 2", error_count); end
    endtask

    task automatic test_async_reset();
        lock_1100();
        idle(18);
        tests++; if (holdover !== 1'b1) begin fails++; $display("FAIL ar_hold: got %b want 1", holdover); end
        reset_n = 1'b0;
        #1;
        tests++; if ({phase_locked, holdover, revo_out} !== 3'b000) begin fails++; $display("FAIL ar_flags: got %b want 000", {phase_locked, holdover, revo_out}); end
        tests++; if (select2 !== 2'b00 || select4 !== 4'b0000) begin fails++; $display("FAIL ar_sel: got %b/%b want 00/0000", select2, select4); end
        tests++; if (error_count !== 8'd0) begin fails++; $display("FAIL ar_err: got %0d want 0", error_count); end
        #2;
        reset_n = 1'b1;
        idle(1);
        tests++; if ({phase_locked, holdover, revo_out, select2} !== 5'b00000) begin fails++; $display("FAIL ar_release: got %b want 00000", {phase_locked, holdover, revo_out, select2}); end
    endtask

    initial begin
        test_reset();
        test_verify_abort();
        test_lock();
        test_jitter();
        test_holdover();
        test_recovery();
        test_relock();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
